// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle sliced magnitude comparator with start/done handshake
module comparator_seq #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_greater,
  output logic             a_equal,
  output logic             a_less
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d;
  logic             found_gt_q, found_gt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [DIGIT-1:0] slice_a, slice_b;
  logic             slice_diff, slice_gt;
  logic             fin, fin_gt, fin_eq;

  assign slice_a    = a_q[int'(idx_q) * DIGIT +: DIGIT];
  assign slice_b    = b_q[int'(idx_q) * DIGIT +: DIGIT];
  assign slice_diff = (slice_a != slice_b);
  assign slice_gt   = (slice_a > slice_b);

  // State and result registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      found_q    <= 1'b0;
      found_gt_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      found_q    <= found_d;
      found_gt_q <= found_gt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
    end
  end

  // Next-state: capture on start, walk slices MSB first, finish on decisive or last slice.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    found_d    = found_q;
    found_gt_d = found_gt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gt_d       = gt_q;
    eq_d       = eq_q;
    lt_d       = lt_q;
    fin        = 1'b0;
    fin_gt     = 1'b0;
    fin_eq     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = signed_mode ? (a ^ MSB_MASK) : a;
          b_d        = signed_mode ? (b ^ MSB_MASK) : b;
          idx_d      = LAST_IDX;
          found_d    = 1'b0;
          found_gt_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (slice_diff && (EARLY_EXIT != 0)) begin
          fin    = 1'b1;
          fin_gt = slice_gt;
        end else if (idx_q == '0) begin
          fin = 1'b1;
          if (found_q) begin
            fin_gt = found_gt_q;
          end else if (slice_diff) begin
            fin_gt = slice_gt;
          end else begin
            fin_eq = 1'b1;
          end
        end else begin
          idx_d = idx_q - 1'b1;
          // Only the first differing slice decides; later slices cannot override it.
          if (slice_diff && !found_q) begin
            found_d    = 1'b1;
            found_gt_d = slice_gt;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      eq_d    = fin_eq;
      gt_d    = !fin_eq && fin_gt;
      lt_d    = !fin_eq && !fin_gt;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign a_greater = gt_q;
  assign a_equal   = eq_q;
  assign a_less    = lt_q;

endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - randomized self-checking bench for comparator_seq
module tb_comparator_seq;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_ee, start_fx;
  logic         signed_mode;
  logic [W-1:0] a, b;
  logic         busy_ee, done_ee, gt_ee, eq_ee, lt_ee;
  logic         busy_fx, done_fx, gt_fx, eq_fx, lt_fx;

  int           checks = 0;
  int           errors = 0;
  logic [2:0]   prev_flags [2];

  always #5 clk = ~clk;

  comparator_seq #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst(rst), .start(start_ee), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_ee), .done(done_ee),
    .a_greater(gt_ee), .a_equal(eq_ee), .a_less(lt_ee)
  );

  comparator_seq #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) dut_fx (
    .clk(clk), .rst(rst), .start(start_fx), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_fx), .done(done_fx),
    .a_greater(gt_fx), .a_equal(eq_fx), .a_less(lt_fx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic obs_busy(input bit fx);
    return fx ? busy_fx : busy_ee;
  endfunction

  function automatic logic obs_done(input bit fx);
    return fx ? done_fx : done_ee;
  endfunction

  function automatic logic [2:0] obs_flags(input bit fx);
    return fx ? {gt_fx, eq_fx, lt_fx} : {gt_ee, eq_ee, lt_ee};
  endfunction

  // Reference result {gt, eq, lt} from plain arithmetic on sign/zero-extended operands.
  function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm);
    logic signed [W:0] sx, sy;
    sx = sm ? $signed({x[W-1], x}) : $signed({1'b0, x});
    sy = sm ? $signed({y[W-1], y}) : $signed({1'b0, y});
    if (sx > sy) return 3'b100;
    if (sx == sy) return 3'b010;
    return 3'b001;
  endfunction

  // Slices examined: all of them, or down to the slice holding the highest differing bit.
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
    logic [W-1:0] d;
    d = x ^ y;
    if (!ee || d == '0) return N;
    for (int p = W - 1; p >= 0; p--)
      if (d[p]) return N - p / D;
    return N;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit fx, input logic v);
    if (fx) start_fx = v;
    else start_ee = v;
  endtask

  // Steps until done, checking that flags hold meanwhile; n = cycles waited (bounded).
  task automatic wait_done(input bit fx, input string tag, output int n);
    bit got;
    n   = 0;
    got = 0;
    while (n < 3 * N && !got) begin
      step();
      n++;
      if (obs_done(fx)) got = 1;
      else check({tag, "/hold"}, 32'(obs_flags(fx)), 32'(prev_flags[fx]));
    end
    if (!got) n = 999;
  endtask

  task automatic finish_cmp(input bit fx, input string tag, input int n, input int lat,
                            input logic [2:0] exp);
    check({tag, "/lat"}, 32'(n), 32'(lat));
    check({tag, "/flags"}, 32'(obs_flags(fx)), 32'(exp));
    check({tag, "/busy_done"}, 32'(obs_busy(fx)), 32'(0));
    prev_flags[fx] = exp;
    step();
    check({tag, "/done_pulse"}, 32'(obs_done(fx)), 32'(0));
    check({tag, "/keep"}, 32'(obs_flags(fx)), 32'(exp));
  endtask

  task automatic run_cmp(input string tag, input bit fx, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_, input bit sm);
    int n;
    a           = ta;
    b           = tb_;
    signed_mode = sm;
    set_start(fx, 1'b1);
    step();
    check({tag, "/busy"}, 32'(obs_busy(fx)), 32'(1));
    set_start(fx, 1'b0);
    a           = W'($urandom);
    b           = W'($urandom);
    signed_mode = 1'($urandom);
    wait_done(fx, tag, n);
    finish_cmp(fx, tag, n, ref_lat(ta, tb_, !fx), ref_flags(ta, tb_, sm));
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    start_ee = 1'b0;
    start_fx = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      check("reset/busy", 32'(obs_busy(f[0])), 32'(0));
      check("reset/done", 32'(obs_done(f[0])), 32'(0));
      check("reset/flags", 32'(obs_flags(f[0])), 32'(0));
      prev_flags[f] = 3'b000;
    end

    run_cmp("lsb", 0, 16'h1234, 16'h1235, 0);
    run_cmp("equal", 0, 16'hBEEF, 16'hBEEF, 0);
    run_cmp("equal_s", 0, 16'hBEEF, 16'hBEEF, 1);
    run_cmp("msb_u", 0, 16'h8000, 16'h7FFF, 0);
    run_cmp("msb_s", 0, 16'h8000, 16'h7FFF, 1);
    run_cmp("neg_one", 0, 16'hFFFF, 16'h0000, 1);
    run_cmp("fx_msb", 1, 16'hF000, 16'h0000, 0);
    run_cmp("fx_first", 1, 16'h1200, 16'h1100, 0);
    run_cmp("fx_lsb", 1, 16'h1234, 16'h1235, 0);

    // start re-asserted while busy must not disturb the captured operands
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start_ee = 1'b1;
    step();
    check("ign/busy", 32'(busy_ee), 32'(1));
    a = 16'hFFFF;
    step();
    start_ee = 1'b0;
    wait_done(0, "ign", n);
    finish_cmp(0, "ign", n + 1, 4, 3'b001);

    // start held through the done cycle gives a back-to-back compare
    a = 16'h0001; b = 16'h0002; start_ee = 1'b1;
    step();
    a = 16'h0005; b = 16'h0003;
    wait_done(0, "b2b1", n);
    check("b2b1/lat", 32'(n), 32'(4));
    check("b2b1/flags", 32'({gt_ee, eq_ee, lt_ee}), 32'(3'b001));
    check("b2b1/busy_done", 32'(busy_ee), 32'(0));
    prev_flags[0] = 3'b001;
    step();
    check("b2b2/busy", 32'(busy_ee), 32'(1));
    start_ee = 1'b0;
    wait_done(0, "b2b2", n);
    finish_cmp(0, "b2b2", n, 4, 3'b100);

    // reset mid-operation, with a simultaneous start that reset must override
    a = 16'h0001; b = 16'h0002; start_ee = 1'b1;
    step();
    start_ee = 1'b0;
    step();
    check("rst/no_done", 32'(done_ee), 32'(0));
    rst = 1'b1;
    start_ee = 1'b1;
    step();
    check("rst/busy", 32'(busy_ee), 32'(0));
    check("rst/done", 32'(done_ee), 32'(0));
    check("rst/flags", 32'({gt_ee, eq_ee, lt_ee}), 32'(0));
    check("rst/flags_fx", 32'({gt_fx, eq_fx, lt_fx}), 32'(0));
    prev_flags[0] = 3'b000;
    prev_flags[1] = 3'b000;
    rst = 1'b0;
    start_ee = 1'b0;
    step();
    check("rst/idle", 32'(busy_ee), 32'(0));
    run_cmp("after_rst", 0, 16'h4321, 16'h4320, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp($sformatf("rnd%0d", i), i[0], ra, rb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Parametrised, multi-cycle magnitude comparator with a start/done handshake.
- Compares two WIDTH-bit operands one DIGIT-bit slice per cycle, MSB slice first.
- Supports unsigned and two's-complement signed modes, and optional early termination.
- Used where wide operands make a single-cycle comparator too slow. Produces the same three-flag result (greater/equal/less) as our combinational comparators.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH.
- EARLY_EXIT, 1, 1 = finish on the first differing slice; 0 = always scan all slices (fixed latency).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when busy=0.
- signed_mode  input  1  1 = operands are two's complement; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse; result flags valid from this cycle on.
- a_greater  output  1  A > B.
- a_equal  output  1  A == B.
- a_less  output  1  A < B.

Behaviour:
- Reset and outputs:
  - Reset is synchronous: clk and rst are the only clock and reset, rst is active-high, and it is sampled only on the rising edge of clk.
  - After reset: busy=0, done=0, a_greater=0, a_equal=0, a_less=0. The FSM is in IDLE and the slice counter is 0.
  - All outputs are registered.
- FSM states: IDLE, RUN.
- Start (IDLE, start=1 at edge t):
  - Capture a, b and signed_mode into internal registers.
  - If signed_mode=1, invert bit WIDTH-1 of both captured operands. This makes the signed order equal the unsigned order.
  - Set the slice index to N-1, where N = WIDTH/DIGIT. Go to RUN; busy=1 from edge t.
- RUN, one slice per cycle:
  - Compare slice [i*DIGIT +: DIGIT] of the captured A and B as unsigned values.
  - Decisive slice: the slices differ and EARLY_EXIT=1. Latch the greater/less result.
  - Last slice (i=0): latch the result of the first differing slice; if no slice differed, latch equal.
  - Otherwise: decrement i and stay in RUN.
  - On a decisive or last slice, at that edge: update the flags (exactly one high), pulse done=1, set busy=0 and return to IDLE.
  - With EARLY_EXIT=0, the first differing slice is remembered and later slices do not override it.
- Latency:
  - Let k = number of slices examined. done is high in the cycle that starts at edge t+k.
  - EARLY_EXIT=0 or equal operands: k = N.
  - Minimum: k = 1 (MSB slice differs, EARLY_EXIT=1).
- Flags change only at the done edge. They hold their value until the next done or reset. They do not clear on start.
- start while busy=1: ignored; the captured operands are not disturbed.
- start in the done cycle: accepted, because busy=0 in that cycle. This gives back-to-back operation with no idle cycle.
- rst mid-operation:
  - The operation is abandoned, with no done pulse.
  - All outputs return to their reset values in the cycle after the edge.
  - rst overrides a simultaneous start.
- DIGIT = WIDTH: a single slice, so every compare has k = 1.
- Inputs a, b and signed_mode may change freely while busy=1.

Test Plan (WIDTH=16, DIGIT=4, EARLY_EXIT=1 unless stated):
- Differ in LSB slice: unsigned a=16'h1234, b=16'h1235 -> done 4 cycles after the start edge, a_less=1, a_greater=0, a_equal=0.
- Equal operands: a=b=16'hBEEF -> done after 4 cycles, a_equal=1, other flags 0.
- MSB slice differs, both modes:
  - a=16'h8000, b=16'h7FFF, signed_mode=0 -> done after 1 cycle, a_greater=1.
  - Same operands, signed_mode=1 -> done after 1 cycle, a_less=1.
  - Signed a=16'hFFFF (-1), b=16'h0000 -> a_less=1.
- Handshake:
  - Pulse start with a=16'h0001, b=16'h0002. Re-assert start 1 cycle later with a=16'hFFFF -> the second start is ignored; the result is a_less=1 after 4 cycles.
  - Hold start=1 through the done cycle with new operands a=16'h0005, b=16'h0003 -> the second compare begins immediately; its done arrives 4 cycles later with a_greater=1.
- Reset mid-operation: assert rst 2 cycles after start -> no done pulse; busy=0 and all flags 0 after the next edge. A following start then completes normally.
- Fixed latency (EARLY_EXIT=0): a=16'hF000, b=16'h0000 -> done after 4 cycles, a_greater=1 (not after 1). Separately, a=16'h1200, b=16'h1100 -> a_greater=1; the later slices do not override the first differing slice.
